// File: rtl/stat_sequencer.sv
// Sequential front end for the combinational statistics calculator: collects a
// four-sample window, issues each enabled operation one-hot, streams tagged results.
module stat_sequencer #(
  parameter logic [3:0] OP_MASK = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] Numbers [1:4],
  output logic [3:0] OP,
  input  logic [7:0] Result,
  input  logic       Max,
  input  logic       Min,
  input  logic       Mean,
  input  logic       Var,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_tag,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       flag_err
);

  typedef enum logic [1:0] {LOAD, ISSUE, CAPTURE, SEND} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       done_d;

  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] op_onehot_q, op_onehot_d;
  logic       frame_done_q;
  logic [7:0] out_data_q;
  logic [1:0] out_tag_q;
  logic       flag_err_q;
  logic [3:0] numbers_q [1:4];

  logic       accept, send_hs;
  logic [3:0] en_by_tag, later_en;

  // Enables re-indexed by tag (bit 0 = max ... bit 3 = var); later_en keeps tags after op_q.
  assign en_by_tag = {OP_MASK[0], OP_MASK[1], OP_MASK[2], OP_MASK[3]};
  assign later_en  = en_by_tag & (4'b1110 << op_q);
  assign accept    = in_valid & in_ready_q;
  assign send_hs   = out_valid_q & out_ready;

  function automatic logic [1:0] lowest_tag(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (|en_by_tag) begin
              state_d = ISSUE;
              op_d    = lowest_tag(en_by_tag);
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND: begin
        if (send_hs) begin
          if (|later_en) begin
            state_d = ISSUE;
            op_d    = lowest_tag(later_en);
          end else begin
            state_d = LOAD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == SEND);
    op_onehot_d = (state_d == ISSUE || state_d == CAPTURE) ? (4'b1000 >> op_d) : 4'b0000;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      op_onehot_q  <= 4'b0000;
      frame_done_q <= 1'b0;
      out_data_q   <= 8'd0;
      out_tag_q    <= 2'd0;
      flag_err_q   <= 1'b0;
      // NOTE: the sample window is a visible output with a defined reset value,
      // so this small array is reset, unlike a storage memory.
      for (int i = 1; i <= 4; i++) numbers_q[i] <= 4'd0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      op_onehot_q  <= op_onehot_d;
      frame_done_q <= done_d;
      if (accept) numbers_q[3'(cnt_q) + 3'd1] <= in_data;
      if (state_q == CAPTURE) begin
        out_data_q <= Result;
        out_tag_q  <= op_q;
        if ({Max, Min, Mean, Var} != op_onehot_q) flag_err_q <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign Numbers    = numbers_q;
  assign OP         = op_onehot_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign frame_done = frame_done_q;
  assign flag_err   = flag_err_q;

endmodule

// File: tb/tb_stat_sequencer.sv
// Bench for stat_sequencer: three instances (masks 1111, 0101, 0000) share the
// stimulus; a transaction-level model is compared against every output each cycle.
module tb_stat_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b1;
  logic       inject_err = 1'b0;

  logic       rdy0, rdy1, rdy2, ov0, ov1, ov2, fd0, fd1, fd2, fe0, fe1, fe2;
  logic [3:0] op0, op1, op2, flg0, flg1, flg2;
  logic [7:0] res0, res1, res2, od0, od1, od2;
  logic [1:0] ot0, ot1, ot2;
  logic [3:0] n0 [1:4];
  logic [3:0] n1 [1:4];
  logic [3:0] n2 [1:4];

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] calc(input logic [1:0] tag, input logic [3:0] a, b, c, d);
    int v[4];
    int s, q, mx, mn;
    v = '{int'(a), int'(b), int'(c), int'(d)};
    s = 0; q = 0; mx = 0; mn = 15;
    foreach (v[k]) begin
      s += v[k];
      q += v[k] * v[k];
      if (v[k] > mx) mx = v[k];
      if (v[k] < mn) mn = v[k];
    end
    case (tag)
      2'd0:    return 8'(mx);
      2'd1:    return 8'(mn);
      2'd2:    return 8'(s / 4);
      default: return 8'((4 * q - s * s) / 16);
    endcase
  endfunction

  function automatic logic [1:0] tag_of(input logic [3:0] op);
    case (op)
      4'b1000: return 2'd0;
      4'b0100: return 2'd1;
      4'b0010: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Calculator stand-ins: a real calculator, a tag stub, and a silent one.
  always_comb begin
    res0 = (op0 != 4'd0) ? calc(tag_of(op0), n0[1], n0[2], n0[3], n0[4]) : 8'h00;
    flg0 = op0 | ((inject_err && op0 == 4'b1000) ? 4'b0100 : 4'b0000);
    res1 = (op1 != 4'd0) ? 8'hA0 + {6'd0, tag_of(op1)} : 8'h00;
    flg1 = op1;
    res2 = 8'h00;
    flg2 = op2;
  end

  stat_sequencer #(.OP_MASK(4'b1111)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .Numbers(n0), .OP(op0), .Result(res0),
    .Max(flg0[3]), .Min(flg0[2]), .Mean(flg0[1]), .Var(flg0[0]),
    .out_valid(ov0), .out_data(od0), .out_tag(ot0), .out_ready(out_ready),
    .frame_done(fd0), .flag_err(fe0));

  stat_sequencer #(.OP_MASK(4'b0101)) u_mask (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .Numbers(n1), .OP(op1), .Result(res1),
    .Max(flg1[3]), .Min(flg1[2]), .Mean(flg1[1]), .Var(flg1[0]),
    .out_valid(ov1), .out_data(od1), .out_tag(ot1), .out_ready(out_ready),
    .frame_done(fd1), .flag_err(fe1));

  stat_sequencer #(.OP_MASK(4'b0000)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .Numbers(n2), .OP(op2), .Result(res2),
    .Max(flg2[3]), .Min(flg2[2]), .Mean(flg2[1]), .Var(flg2[0]),
    .out_valid(ov2), .out_data(od2), .out_tag(ot2), .out_ready(out_ready),
    .frame_done(fd2), .flag_err(fe2));

  logic [2:0]             a_rdy, a_ov, a_fd, a_fe;
  logic [2:0][3:0]        a_op;
  logic [2:0][7:0]        a_od;
  logic [2:0][1:0]        a_ot;
  logic [2:0][4:1][3:0]   a_num;
  assign a_rdy = {rdy2, rdy1, rdy0};
  assign a_ov  = {ov2, ov1, ov0};
  assign a_fd  = {fd2, fd1, fd0};
  assign a_fe  = {fe2, fe1, fe0};
  assign a_op  = {op2, op1, op0};
  assign a_od  = {od2, od1, od0};
  assign a_ot  = {ot2, ot1, ot0};
  assign a_num = {n2[4], n2[3], n2[2], n2[1], n1[4], n1[3], n1[2], n1[1],
                  n0[4], n0[3], n0[2], n0[1]};

  // Transaction model: a frame is a window plus a queue of enabled ops; each op
  // is requested for two cycles, then offered until the consumer takes it.
  localparam logic [3:0] MASK [3] = '{4'b1111, 4'b0101, 4'b0000};
  bit         m_live = 1'b0;
  bit         m_started [3];
  bit         m_busy [3];
  bit         m_done [3];
  bit         m_flag [3];
  int         m_cnt [3];
  int         m_age [3];
  logic [3:0] m_num [3][1:4];
  logic [7:0] m_data [3];
  logic [1:0] m_tag [3];
  int         m_todo [3][$];

  always @(posedge clk) begin
    bit nd;
    int tg;
    m_live = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_started[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_flag[i] = 1'b0;
        m_cnt[i] = 0; m_age[i] = 0; m_data[i] = 8'd0; m_tag[i] = 2'd0;
        for (int k = 1; k <= 4; k++) m_num[i][k] = 4'd0;
        m_todo[i].delete();
      end else begin
        nd = 1'b0;
        if (!m_busy[i]) begin
          if (m_started[i] && in_valid) begin
            m_num[i][m_cnt[i] + 1] = in_data;
            m_cnt[i]++;
            if (m_cnt[i] == 4) begin
              m_cnt[i] = 0;
              for (int t = 0; t < 4; t++)
                if ((MASK[i] & (4'b1000 >> t)) != 4'd0) m_todo[i].push_back(t);
              if (m_todo[i].size() == 0) nd = 1'b1;
              else begin m_busy[i] = 1'b1; m_age[i] = 0; end
            end
          end
        end else if (m_age[i] == 0) begin
          m_age[i] = 1;
        end else if (m_age[i] == 1) begin
          tg = m_todo[i][0];
          m_data[i] = (i == 1) ? 8'hA0 + 8'(tg)
                               : calc(2'(tg), m_num[i][1], m_num[i][2], m_num[i][3], m_num[i][4]);
          m_tag[i] = 2'(tg);
          if (i == 0 && inject_err && tg == 0) m_flag[i] = 1'b1;
          m_age[i] = 2;
        end else if (out_ready) begin
          void'(m_todo[i].pop_front());
          if (m_todo[i].size() == 0) begin m_busy[i] = 1'b0; nd = 1'b1; end
          else m_age[i] = 0;
        end
        m_done[i] = nd;
        m_started[i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]  e_op;
    logic [15:0] e_num;
    if (m_live) begin
      for (int i = 0; i < 3; i++) begin
        e_op  = (m_busy[i] && m_age[i] < 2) ? (4'b1000 >> m_todo[i][0]) : 4'b0000;
        e_num = {m_num[i][4], m_num[i][3], m_num[i][2], m_num[i][1]};
        check($sformatf("u%0d in_ready", i), a_rdy[i], m_started[i] && !m_busy[i]);
        check($sformatf("u%0d out_valid", i), a_ov[i], m_busy[i] && m_age[i] >= 2);
        check($sformatf("u%0d OP", i), a_op[i], e_op);
        check($sformatf("u%0d Numbers", i), a_num[i], e_num);
        check($sformatf("u%0d out_data", i), a_od[i], m_data[i]);
        check($sformatf("u%0d out_tag", i), a_ot[i], m_tag[i]);
        check($sformatf("u%0d frame_done", i), a_fd[i], m_done[i]);
        check($sformatf("u%0d flag_err", i), a_fe[i], m_flag[i]);
      end
    end
  end

  // Result logs for the hand-computed expectations.
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  int ov2_seen = 0;
  int fd2_cyc = 0;
  always @(negedge clk) begin
    if (ov0 && out_ready) q0.push_back({ot0, od0});
    if (ov1 && out_ready) q1.push_back({ot1, od1});
    if (ov2) ov2_seen++;
    if (fd2) fd2_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] s0, s1, s2, s3, input int n, output int fc);
    logic [3:0] s [4];
    bit acc;
    int waited;
    s = '{s0, s1, s2, s3};
    fc = -1;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = s[k];
      waited   = 0;
      acc      = 1'b0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = rdy0;
        if (k == 0) fc = cyc;
        tick();
        waited++;
      end
      if (!acc) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int w = 0; w < 200 && c < 0; w++) begin
      @(negedge clk);
      if (fd0) c = cyc;
    end
    if (c < 0) check("frame_done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int fc, cd;
    bit got;
    logic [7:0] held_d;

    // Reset and idle.
    repeat (3) begin
      @(negedge clk);
      check("reset in_ready", rdy0, 0);
      check("reset out_valid", ov0, 0);
    end
    tick();
    rst = 1'b0;
    tick();
    check("in_ready after reset", rdy0, 1);
    check("out_valid idle", ov0, 0);

    // Full frame against the real calculator, plus mask and zero-mask instances.
    q0.delete(); q1.delete();
    send_frame(4'd3, 4'd9, 4'd1, 4'd7, 4, fc);
    wait_done(cd);
    check("full frame_done cycle", cd - fc + 1, 17);
    check("full Numbers", a_num[0], {4'd7, 4'd1, 4'd9, 4'd3});
    check("full result count", q0.size(), 4);
    check("full max", q0[0], {2'd0, 8'd9});
    check("full min", q0[1], {2'd1, 8'd1});
    check("full mean", q0[2], {2'd2, 8'd5});
    check("full var", q0[3], {2'd3, 8'd10});
    check("full flag_err", fe0, 0);
    check("mask result count", q1.size(), 2);
    check("mask first", q1[0], {2'd1, 8'hA1});
    check("mask second", q1[1], {2'd3, 8'hA3});
    check("zero mask frame_done cycle", fd2_cyc - fc + 1, 5);

    // Backpressure during the tag-1 offer.
    q0.delete();
    send_frame(4'd12, 4'd4, 4'd15, 4'd0, 4, fc);
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (op0 == 4'b0100) got = 1'b1;
    end
    check("bp min issue seen", got, 1);
    out_ready = 1'b0;
    tick();
    tick();
    held_d = od0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid held", ov0, 1);
      check("bp out_tag held", ot0, 1);
      check("bp out_data held", od0, held_d);
      check("bp OP idle", op0, 0);
      check("bp in_ready low", rdy0, 0);
      tick();
    end
    check("bp min value", held_d, 8'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp still offered", ov0, 1);
    tick();
    @(negedge clk);
    check("bp next issue", op0, 4'b0010);
    wait_done(cd);
    check("bp result count", q0.size(), 4);

    // Flag mismatch: sets after capture, stays through the next frame, clears on rst.
    inject_err = 1'b1;
    send_frame(4'd2, 4'd8, 4'd5, 4'd1, 4, fc);
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (ov0 && ot0 == 2'd0) got = 1'b1;
    end
    check("flag first send seen", got, 1);
    check("flag set after capture", fe0, 1);
    wait_done(cd);
    inject_err = 1'b0;
    send_frame(4'd6, 4'd6, 4'd6, 4'd6, 4, fc);
    wait_done(cd);
    check("flag sticky", fe0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flag cleared by rst", fe0, 0);
    tick();

    // Mid-frame reset after two samples, then a fresh frame.
    send_frame(4'd11, 4'd13, 4'd0, 4'd0, 2, fc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort Numbers cleared", a_num[0], 16'd0);
    check("abort out_valid", ov0, 0);
    tick();
    q0.delete();
    send_frame(4'd5, 4'd6, 4'd7, 4'd8, 4, fc);
    check("fresh Numbers", a_num[0], {4'd8, 4'd7, 4'd6, 4'd5});
    wait_done(cd);
    check("fresh max", q0[0], {2'd0, 8'd8});

    // Reset while a result is being offered.
    out_ready = 1'b0;
    send_frame(4'd2, 4'd2, 4'd2, 4'd2, 4, fc);
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (ov0) got = 1'b1;
    end
    check("send reset offer seen", got, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no stale out_valid", ov0, 0);
      check("no stale frame_done", fd0, 0);
    end
    tick();
    send_frame(4'd1, 4'd2, 4'd3, 4'd4, 4, fc);
    wait_done(cd);
    check("recovered frame_done cycle", cd - fc + 1, 17);
    check("zero mask never valid", ov2_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
